// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
//   Shared constants for the mesh NoC router datapath.
//   FLIT_W           default flit width in bits
//   PORT_FIFO_DEPTH  default entries per router input-port FIFO (power of two)
//   PORT_FIFO_AF     default almost-full threshold (occupancy) for back-pressure
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int FLIT_W          = 8;
    localparam int PORT_FIFO_DEPTH = 8;
    localparam int PORT_FIFO_AF    = 6;

endpackage : noc_pkg

// File: rtl/noc_fifo_mem.sv
// -----------------------------------------------------------------------------
// noc_fifo_mem
//   DEPTH x DATA_W simple dual-port flit storage: one synchronous write port and
//   one registered read port with enable. The read register is the FIFO's
//   data_out, so it holds its value whenever no read is enabled.
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset (clears the read register only)
//   i_wr_en    in   write enable
//   i_wr_addr  in   write address
//   i_wr_data  in   write data
//   i_rd_en    in   read enable; loads o_rd_data from i_rd_addr
//   i_rd_addr  in   read address
//   o_rd_data  out  registered read data
// -----------------------------------------------------------------------------
module noc_fifo_mem
    import noc_pkg::*;
#(
    parameter int DATA_W = FLIT_W,
    parameter int DEPTH  = PORT_FIFO_DEPTH
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic                       i_rd_en,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
    output logic [DATA_W-1:0]          o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // NOTE: the array has no reset so it maps onto plain RAM/flop arrays;
    // stale contents are never visible because the pointers and count gate reads.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // A read and write of the same slot on one edge returns the old contents,
    // which is what the full-FIFO simultaneous read/write case relies on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : noc_fifo_mem

// File: rtl/noc_port_fifo.sv
// -----------------------------------------------------------------------------
// noc_port_fifo
//   Flit buffer for one router input port. Circular buffer with registered read
//   data, exact occupancy count, full/empty/almost-full flags decoded from the
//   count register, and sticky overflow/underflow error flags.
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset; discards all contents
//   write        in   write request; data_in sampled on the same edge
//   data_in      in   flit to enqueue
//   read         in   read request
//   clr_err      in   synchronous clear of overflow/underflow (a new error wins)
//   data_out     out  registered dequeued flit; holds when no read is accepted
//   data_valid   out  one-cycle pulse when data_out was loaded by an accepted read
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_LEVEL
//   count        out  current occupancy
//   overflow     out  sticky: write while full with no read accepted
//   underflow    out  sticky: read while empty
// -----------------------------------------------------------------------------
module noc_port_fifo
    import noc_pkg::*;
#(
    parameter int DATA_W   = FLIT_W,
    parameter int DEPTH    = PORT_FIFO_DEPTH,
    parameter int AF_LEVEL = PORT_FIFO_AF
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         write,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         read,
    input  logic                         clr_err,
    output logic [DATA_W-1:0]            data_out,
    output logic                         data_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_data_valid;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_rd_acc;
    logic          w_wr_acc;
    logic [CW-1:0] w_count_next;

    // Flags decode the count register directly, so they never lag it.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A write into a full FIFO is still accepted when a read frees a slot on
    // the same edge; a read from an empty FIFO is never bypassed from data_in.
    assign w_rd_acc = read & ~w_empty;
    assign w_wr_acc = write & (~w_full | w_rd_acc);

    // NOTE: always_comb assigns a default before the case so that every path
    // drives w_count_next and no latch is inferred.
    always_comb begin
        w_count_next = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_data_valid <= 1'b0;
        end else begin
            // Pointers wrap DEPTH-1 -> 0 by natural modulo (DEPTH is a power of two).
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count      <= w_count_next;
            r_data_valid <= w_rd_acc;
        end
    end

    // Sticky error flags; a new error on the same edge as clr_err wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write & w_full & ~w_rd_acc) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (read & w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    noc_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (data_out)
    );

    assign data_valid  = r_data_valid;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (r_count >= CW'(AF_LEVEL));
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule : noc_port_fifo

// File: tb/tb_noc_port_fifo.sv
// -----------------------------------------------------------------------------
// tb_noc_port_fifo
//   Two FIFO instances share one stimulus stream: dut_a (DEPTH=8, AF_LEVEL=6)
//   and dut_b (DEPTH=16, AF_LEVEL=12). A queue-based reference model tracks
//   both and is compared after every clock; directed tables and sequences add
//   explicit expectations for the corner cases.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_noc_port_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       write;
    logic [7:0] data_in;
    logic       read;
    logic       clr_err;

    logic [7:0] a_dout, b_dout;
    logic       a_dv, a_full, a_empty, a_af, a_ovf, a_unf;
    logic       b_dv, b_full, b_empty, b_af, b_ovf, b_unf;
    logic [3:0] a_cnt;
    logic [4:0] b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    noc_port_fifo #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6)) dut_a (
        .clk(clk), .rst(rst), .write(write), .data_in(data_in), .read(read),
        .clr_err(clr_err), .data_out(a_dout), .data_valid(a_dv), .full(a_full),
        .empty(a_empty), .almost_full(a_af), .count(a_cnt), .overflow(a_ovf),
        .underflow(a_unf)
    );

    noc_port_fifo #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(12)) dut_b (
        .clk(clk), .rst(rst), .write(write), .data_in(data_in), .read(read),
        .clr_err(clr_err), .data_out(b_dout), .data_valid(b_dv), .full(b_full),
        .empty(b_empty), .almost_full(b_af), .count(b_cnt), .overflow(b_ovf),
        .underflow(b_unf)
    );

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [4:0] cnt, input logic full, input logic empty,
                                         input logic af, input logic [7:0] dout, input logic dv,
                                         input logic ovf, input logic unf);
        return {13'd0, cnt, full, empty, af, dout, dv, ovf, unf};
    endfunction

    function automatic logic [31:0] act_a();
        return pack({1'b0, a_cnt}, a_full, a_empty, a_af, a_dout, a_dv, a_ovf, a_unf);
    endfunction

    function automatic logic [31:0] act_b();
        return pack(b_cnt, b_full, b_empty, b_af, b_dout, b_dv, b_ovf, b_unf);
    endfunction

    // ---------------- reference model (queue of flits per instance) ----------------
    logic [7:0] mq [2][$];
    logic [7:0] m_dout [2];
    logic       m_dv   [2];
    logic       m_ovf  [2];
    logic       m_unf  [2];

    function automatic int depth_of(input int i);
        return (i == 0) ? 8 : 16;
    endfunction

    function automatic int af_of(input int i);
        return (i == 0) ? 6 : 12;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_dout[i] = 8'h00;
            m_dv[i]   = 1'b0;
            m_ovf[i]  = 1'b0;
            m_unf[i]  = 1'b0;
        end
    endtask

    // One clock edge of FIFO behaviour, from the current request inputs.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int  sz;
            bit  rd;
            bit  wr;
            sz = mq[i].size();
            rd = read && (sz > 0);
            wr = write && ((sz < depth_of(i)) || rd);
            if (write && (sz == depth_of(i)) && !rd) m_ovf[i] = 1'b1;
            else if (clr_err)                        m_ovf[i] = 1'b0;
            if (read && (sz == 0)) m_unf[i] = 1'b1;
            else if (clr_err)      m_unf[i] = 1'b0;
            if (rd) begin
                m_dout[i] = mq[i].pop_front();
                m_dv[i]   = 1'b1;
            end else begin
                m_dv[i]   = 1'b0;
            end
            if (wr) mq[i].push_back(data_in);
        end
    endtask

    task automatic compare_model();
        for (int i = 0; i < 2; i++) begin
            int sz;
            logic [31:0] exp;
            sz  = mq[i].size();
            exp = pack(5'(sz), sz == depth_of(i), sz == 0, sz >= af_of(i),
                       m_dout[i], m_dv[i], m_ovf[i], m_unf[i]);
            check($sformatf("model dut_%s", (i == 0) ? "a" : "b"), (i == 0) ? act_a() : act_b(), exp);
        end
    endtask

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        write   = w;
        data_in = d;
        read    = r;
        clr_err = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs checked before any edge.
    task automatic do_reset();
        write   = 1'b0;
        read    = 1'b0;
        clr_err = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_model();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_model();
    endtask

    // ---------------- directed vector table (dut_a, DEPTH=8, AF=6) ----------------
    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        logic       c;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic [7:0] dout;
        logic       dv;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic w, input logic [7:0] d, input logic r, input logic c,
                                input int cnt, input logic [7:0] dout, input logic dv,
                                input logic ovf, input logic unf);
        vec_t v;
        v.w = w; v.d = d; v.r = r; v.c = c;
        v.cnt   = 5'(cnt);
        v.full  = (cnt == 8);
        v.empty = (cnt == 0);
        v.af    = (cnt >= 6);
        v.dout  = dout; v.dv = dv; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d8;
        int         pw;
        int         pr;

        // Fill 0x11..0x88, overflow attempt, clear, drain, then empty-side corners.
        for (int k = 0; k < 8; k++) tbl[k] = mk(1, 8'(8'h11 * (k + 1)), 0, 0, k + 1, 8'h00, 0, 0, 0);
        tbl[8] = mk(1, 8'h99, 0, 0, 8, 8'h00, 0, 1, 0);
        tbl[9] = mk(0, 8'h00, 0, 1, 8, 8'h00, 0, 0, 0);
        for (int k = 0; k < 8; k++) tbl[10 + k] = mk(0, 8'h00, 1, 0, 7 - k, 8'(8'h11 * (k + 1)), 1, 0, 0);
        tbl[18] = mk(0, 8'h00, 0, 0, 0, 8'h88, 0, 0, 0);
        tbl[19] = mk(1, 8'h3C, 1, 0, 1, 8'h88, 0, 0, 1);
        tbl[20] = mk(0, 8'h00, 1, 0, 0, 8'h3C, 1, 0, 1);
        tbl[21] = mk(0, 8'h00, 0, 1, 0, 8'h3C, 0, 0, 0);

        rst = 1'b1; write = 1'b0; read = 1'b0; clr_err = 1'b0; data_in = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset state a", act_a(), pack(5'd0, 0, 1, 0, 8'h00, 0, 0, 0));
        check("reset state b", act_b(), pack(5'd0, 0, 1, 0, 8'h00, 0, 0, 0));
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
            check($sformatf("table[%0d]", i), act_a(),
                  pack(tbl[i].cnt, tbl[i].full, tbl[i].empty, tbl[i].af,
                       tbl[i].dout, tbl[i].dv, tbl[i].ovf, tbl[i].unf));
        end

        // Reset mid-stream discards contents; next read underflows with no data_valid.
        step(1, 8'hD1, 0, 0);
        step(1, 8'hD2, 1, 0);
        step(1, 8'hD3, 0, 0);
        do_reset();
        check("midreset empty", {31'd0, a_empty}, 32'd1);
        check("midreset count", {28'd0, a_cnt}, 32'd0);
        check("midreset dout", {24'd0, a_dout}, 32'd0);
        step(0, 8'h00, 1, 0);
        check("post-reset read underflow", {31'd0, a_unf}, 32'd1);
        check("post-reset read dv", {31'd0, a_dv}, 32'd0);
        step(0, 8'h00, 0, 1);

        // Pointer wrap: 5 in / 5 out, then 8 in / 8 out.
        for (int k = 0; k < 5; k++) step(1, 8'(k + 1), 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 8'h00, 1, 0);
            check($sformatf("wrap1 dout[%0d]", k), {24'd0, a_dout}, 32'(k + 1));
        end
        for (int k = 0; k < 8; k++) step(1, 8'(8'h40 + k), 0, 0);
        check("wrap full", {31'd0, a_full}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            step(0, 8'h00, 1, 0);
            check($sformatf("wrap2 dout[%0d]", k), {24'd0, a_dout}, 32'(8'h40 + k));
        end
        check("wrap count", {28'd0, a_cnt}, 32'd0);

        // Simultaneous read + write while full.
        for (int k = 0; k < 8; k++) step(1, 8'(8'hB0 + k), 0, 0);
        step(1, 8'hA5, 1, 0);
        check("full rw dout", {24'd0, a_dout}, 32'hB0);
        check("full rw count", {28'd0, a_cnt}, 32'd8);
        check("full rw ovf", {31'd0, a_ovf}, 32'd0);
        check("full rw dv", {31'd0, a_dv}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            step(0, 8'h00, 1, 0);
            check($sformatf("full rw drain[%0d]", k), {24'd0, a_dout}, (k < 7) ? 32'(8'hB1 + k) : 32'hA5);
        end

        // DEPTH=16 / AF_LEVEL=12 fill and drain on dut_b.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            step(1, 8'(8'h10 + k), 0, 0);
            if (k < 16) check($sformatf("b af at %0d", k + 1), {31'd0, b_af}, (k + 1 >= 12) ? 32'd1 : 32'd0);
        end
        check("b overflow", {31'd0, b_ovf}, 32'd1);
        check("b full", {31'd0, b_full}, 32'd1);
        check("b count", {27'd0, b_cnt}, 32'd16);
        for (int k = 0; k < 16; k++) begin
            step(0, 8'h00, 1, 0);
            check($sformatf("b drain[%0d]", k), {23'd0, b_dv, b_dout}, {23'd0, 1'b1, 8'(8'h10 + k)});
        end
        check("b empty", {31'd0, b_empty}, 32'd1);

        // Randomised traffic in phases of differing read/write pressure.
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            case ((cyc / 500) % 8)
                0: begin pw = 70; pr = 30; end
                1: begin pw = 30; pr = 70; end
                2: begin pw = 90; pr = 10; end
                3: begin pw = 50; pr = 50; end
                4: begin pw = 10; pr = 90; end
                5: begin pw = 95; pr = 60; end
                6: begin pw = 60; pr = 95; end
                default: begin pw = 50; pr = 45; end
            endcase
            if ($urandom_range(999) == 0) begin
                do_reset();
            end else begin
                d8 = 8'($urandom);
                step($urandom_range(99) < pw, d8, $urandom_range(99) < pr, $urandom_range(49) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_noc_port_fifo
